// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word type, instruction-side controller states and limits
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RESP
    } imemctl_state_t;

    localparam int CPUS_MAX = 8;

endpackage

// File: rtl/imem_responder_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr
module rr_arbiter
    import cpu_types_pkg::*;
#(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    logic [N-1:0]  at_or_after;
    logic [PW-1:0] lo_idx;
    logic [PW-1:0] hi_idx;

    // lowest requester overall (wrap case) and lowest requester at or after ptr
    always_comb begin
        at_or_after = '0;
        lo_idx      = '0;
        hi_idx      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            at_or_after[i] = PW'(i) >= ptr;
            lo_idx         = req[i] ? PW'(i) : lo_idx;
            hi_idx         = (req[i] && PW'(i) >= ptr) ? PW'(i) : hi_idx;
        end
    end

    assign any     = |req;
    assign gnt_idx = |(req & at_or_after) ? hi_idx : lo_idx;
    assign gnt_oh  = any ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/imem_responder.sv
// imem_responder: round-robin icache miss service over a single shared RAM read port
module imem_responder
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CPUS-1:0]     iREN,
    input  word_t [CPUS-1:0]    iaddr,
    output logic [CPUS-1:0]     iwait,
    output word_t [CPUS-1:0]    iload,
    output logic                ramREN,
    output word_t               ramaddr,
    input  word_t               ramload,
    input  logic                ramrdy
);

    localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;

    if (CPUS < 1 || CPUS > CPUS_MAX) begin : g_bad_cpus
        $error("imem_responder: CPUS out of range");
    end

    imemctl_state_t state_q, state_d;
    logic [PW-1:0]  gnt_q, gnt_d;
    logic [PW-1:0]  rr_q, rr_d;
    word_t          addr_q, addr_d;
    word_t          data_q, data_d;
    logic [CPUS-1:0] arb_oh;
    logic [PW-1:0]  arb_idx;
    logic           arb_any;
    word_t          sel_addr;
    logic           hit;

    rr_arbiter #(.N(CPUS)) u_arb (
        .req     (iREN),
        .ptr     (rr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // one-hot mux of the winning requester's address
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < CPUS; i++) begin
            sel_addr = sel_addr | (arb_oh[i] ? iaddr[i] : '0);
        end
    end

    // the returned word is only useful if the granted cache still wants that same address
    assign hit = (state_q == RESP) && iREN[gnt_q] && (iaddr[gnt_q] == addr_q);

    // next state: grant in IDLE, wait for RAM in FETCH, advance rr after RESP
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (state_q == IDLE && arb_any) begin
            state_d = FETCH;
            gnt_d   = arb_idx;
            addr_d  = sel_addr;
        end
        if (state_q == FETCH && ramrdy) begin
            state_d = RESP;
            data_d  = ramload;
        end
        if (state_q == RESP) begin
            state_d = IDLE;
            rr_d    = (gnt_q == PW'(CPUS - 1)) ? '0 : gnt_q + 1'b1;
        end
    end

    // state and datapath registers; reset abandons any in-flight read
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign ramREN  = state_q == FETCH;
    assign ramaddr = addr_q;
    assign iload   = {CPUS{data_q}};
    assign iwait   = hit ? ~(CPUS'(1) << gnt_q) : '1;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed scenarios plus an alternating-grant soak against a RAM model
module tb_imem_responder;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        RST;
    logic [1:0]  iREN;
    word_t [1:0] iaddr;
    logic [1:0]  iwait;
    word_t [1:0] iload;
    logic        ramREN;
    word_t       ramaddr;
    word_t       ramload;
    logic        ramrdy;

    int   checks = 0;
    int   errors = 0;
    logic auto_ram = 1'b0;
    int   ram_cnt = 0;

    imem_responder #(.CPUS(2)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iwait   (iwait),
        .iload   (iload),
        .ramREN  (ramREN),
        .ramaddr (ramaddr),
        .ramload (ramload),
        .ramrdy  (ramrdy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic word_t ram_word(word_t a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    // RAM model for the soak: random 1..5 cycle latency, one-cycle ramrdy pulse
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (auto_ram) begin
                if (ramrdy) ramrdy = 1'b0;
                else if (ramREN) begin
                    if (ram_cnt == 0) ram_cnt = int'($urandom_range(1, 5));
                    ram_cnt--;
                    if (ram_cnt == 0) begin
                        ramrdy  = 1'b1;
                        ramload = ram_word(ramaddr);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; iREN = 2'b00; ramrdy = 1'b0;
        tick(); tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; iREN = 2'b11; iaddr[0] = 32'h44; iaddr[1] = 32'h88;
        ramrdy = 1'b1; ramload = 32'hFFFF_FFFF;
        tick();
        checks++; if (iwait !== 2'b11) begin errors++; $display("FAIL rst_iwait got %b want 11", iwait); end
        checks++; if (iload !== 64'h0) begin errors++; $display("FAIL rst_iload got %h want 0", iload); end
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rst_ramREN got %b want 0", ramREN); end
        checks++; if (ramaddr !== 32'h0) begin errors++; $display("FAIL rst_ramaddr got %h want 0", ramaddr); end
        RST = 1'b0; iREN = 2'b00; ramrdy = 1'b0;
        tick();
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL idle_noreq ramREN got %b want 0", ramREN); end
    endtask

    task automatic test_single_miss();
        do_reset();
        iaddr[0] = 32'h40; iaddr[1] = 32'h0; iREN = 2'b01;
        tick();
        checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL miss_ramREN got %b want 1", ramREN); end
        checks++; if (ramaddr !== 32'h40) begin errors++; $display("FAIL miss_ramaddr got %h want 40", ramaddr); end
        checks++; if (iwait !== 2'b11) begin errors++; $display("FAIL miss_fetch_iwait got %b want 11", iwait); end
        tick();
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin errors++; $display("FAIL miss_hold got %b/%h want 1/40", ramREN, ramaddr); end
        tick();
        ramrdy = 1'b1; ramload = 32'hDEAD_BEEF;
        tick();
        ramrdy = 1'b0; ramload = 32'h0;
        checks++; if (iwait !== 2'b10) begin errors++; $display("FAIL miss_resp_iwait got %b want 10", iwait); end
        checks++; if (iload[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_iload got %h want deadbeef", iload[0]); end
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL miss_resp_ramREN got %b want 0", ramREN); end
        tick();
        iREN = 2'b00;
        checks++; if (iwait !== 2'b11) begin errors++; $display("FAIL miss_one_cycle got %b want 11", iwait); end
        tick();
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL miss_no_refetch got %b want 0", ramREN); end
    endtask

    task automatic test_contention();
        do_reset();
        iaddr[0] = 32'h100; iaddr[1] = 32'h200; iREN = 2'b11;
        tick();
        checks++; if (ramaddr !== 32'h100) begin errors++; $display("FAIL cont_first got %h want 100", ramaddr); end
        ramrdy = 1'b1; ramload = 32'h1111_0100;
        tick();
        ramrdy = 1'b0;
        checks++; if (iwait !== 2'b10 || iload[0] !== 32'h1111_0100) begin errors++; $display("FAIL cont_resp0 got %b/%h want 10/11110100", iwait, iload[0]); end
        tick();
        iREN = 2'b10;
        tick();
        checks++; if (ramaddr !== 32'h200 || iwait !== 2'b11) begin errors++; $display("FAIL cont_second got %h/%b want 200/11", ramaddr, iwait); end
        ramrdy = 1'b1; ramload = 32'h2222_0200;
        tick();
        ramrdy = 1'b0;
        checks++; if (iwait !== 2'b01 || iload[1] !== 32'h2222_0200) begin errors++; $display("FAIL cont_resp1 got %b/%h want 01/22220200", iwait, iload[1]); end
        tick();
        iREN = 2'b11;
        tick();
        checks++; if (ramaddr !== 32'h100) begin errors++; $display("FAIL cont_rr_wrap got %h want 100", ramaddr); end
        ramrdy = 1'b1; ramload = 32'h3333_0100;
        tick();
        ramrdy = 1'b0;
        checks++; if (iwait !== 2'b10) begin errors++; $display("FAIL cont_resp0b got %b want 10", iwait); end
        tick();
        iaddr[0] = 32'h104;
        tick();
        checks++; if (ramaddr !== 32'h200) begin errors++; $display("FAIL cont_rr1_cpu1 got %h want 200", ramaddr); end
        ramrdy = 1'b1; ramload = 32'h2222_0200;
        tick();
        ramrdy = 1'b0;
        checks++; if (iwait !== 2'b01 || iload[1] !== 32'h2222_0200) begin errors++; $display("FAIL cont_resp1b got %b/%h want 01/22220200", iwait, iload[1]); end
        tick();
        iREN = 2'b00;
        tick();
    endtask

    task automatic test_stale();
        do_reset();
        iaddr[0] = 32'h80; iREN = 2'b01;
        tick();
        checks++; if (ramaddr !== 32'h80) begin errors++; $display("FAIL stale_fetch got %h want 80", ramaddr); end
        iaddr[0] = 32'h84; ramrdy = 1'b1; ramload = 32'h0000_0080;
        tick();
        ramrdy = 1'b0;
        checks++; if (iwait !== 2'b11) begin errors++; $display("FAIL stale_dropped got %b want 11", iwait); end
        tick();
        checks++; if (iwait !== 2'b11 || ramREN !== 1'b0) begin errors++; $display("FAIL stale_idle got %b/%b want 11/0", iwait, ramREN); end
        tick();
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h84) begin errors++; $display("FAIL stale_refetch got %b/%h want 1/84", ramREN, ramaddr); end
        ramrdy = 1'b1; ramload = 32'h0000_0084;
        tick();
        ramrdy = 1'b0;
        checks++; if (iwait !== 2'b10 || iload[0] !== 32'h0000_0084) begin errors++; $display("FAIL stale_deliver got %b/%h want 10/84", iwait, iload[0]); end
        tick();
        iREN = 2'b00;
        tick();
    endtask

    task automatic test_reset_fetch();
        do_reset();
        iaddr[0] = 32'h300; iREN = 2'b01;
        tick();
        checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL rf_fetch got %b want 1", ramREN); end
        RST = 1'b1;
        tick();
        checks++; if (ramREN !== 1'b0 || iwait !== 2'b11 || ramaddr !== 32'h0) begin errors++; $display("FAIL rf_reset got %b/%b/%h want 0/11/0", ramREN, iwait, ramaddr); end
        RST = 1'b0; iREN = 2'b00; ramrdy = 1'b1; ramload = 32'hBAD0_0300;
        tick();
        ramrdy = 1'b0;
        checks++; if (iwait !== 2'b11 || ramREN !== 1'b0) begin errors++; $display("FAIL rf_late_rdy got %b/%b want 11/0", iwait, ramREN); end
        tick();
        checks++; if (iwait !== 2'b11 || ramREN !== 1'b0) begin errors++; $display("FAIL rf_no_resp got %b/%b want 11/0", iwait, ramREN); end
    endtask

    task automatic test_soak();
        int   grants;
        logic expc;
        logic c;
        logic pend_v;
        logic pend_c;
        do_reset();
        iaddr[0] = 32'h1000; iaddr[1] = 32'h2000; iREN = 2'b11;
        auto_ram = 1'b1; ram_cnt = 0;
        grants = 0; expc = 1'b0; pend_v = 1'b0; pend_c = 1'b0;
        for (int cyc = 0; cyc < 3000 && grants < 200; cyc++) begin
            @(posedge CLK);
            #1;
            if (pend_v) begin
                iaddr[pend_c] = iaddr[pend_c] + 32'h4;
                pend_v = 1'b0;
            end
            #1;
            if (iwait !== 2'b11) begin
                c = iwait[0];
                checks++; if (iwait !== 2'b10 && iwait !== 2'b01) begin errors++; $display("FAIL soak_iwait got %b want 10 or 01", iwait); end
                checks++; if (c !== expc) begin errors++; $display("FAIL soak_order grant %0d got cpu %0d want cpu %0d", grants, c, expc); end
                checks++; if (iload[c] !== ram_word(iaddr[c])) begin errors++; $display("FAIL soak_data got %h want %h", iload[c], ram_word(iaddr[c])); end
                pend_v = 1'b1; pend_c = c;
                expc = ~expc;
                grants++;
            end
        end
        checks++; if (grants != 200) begin errors++; $display("FAIL soak_grants got %0d want 200", grants); end
        auto_ram = 1'b0; iREN = 2'b00;
        tick();
        ramrdy = 1'b0;
    endtask

    initial begin
        RST = 1'b1; iREN = 2'b00; iaddr = '0; ramload = '0; ramrdy = 1'b0;
        test_reset();
        test_single_miss();
        test_contention();
        test_stale();
        test_reset_fetch();
        test_soak();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-side responder for the cache/memory-controller handshake. It accepts fetch misses from `CPUS` icaches (`iREN`/`iaddr`), arbitrates round-robin and issues one RAM read at a time. It returns the word to the granted icache by dropping that cache's `iwait` for exactly one cycle with `iload` valid. It sits between the per-CPU icaches and the shared RAM port, in place of the instruction half of the memory controller.

## Interface
Parameters:
- `CPUS`, default 2: number of icache requesters, range 1..8.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  reset. Synchronous, active-high. Overrides all other inputs.
- `iREN`  in  CPUS  per-CPU fetch request. Level-held by the icache until it sees data.
- `iaddr`  in  CPUS x 32  per-CPU fetch address, word_t.
- `iwait`  out  CPUS  per-CPU wait. 1 = no data this cycle.
- `iload`  out  CPUS x 32  per-CPU returned word. Meaningful only where `iwait` = 0.
- `ramREN`  out  1  RAM read enable.
- `ramaddr`  out  32  RAM read address.
- `ramload`  in  32  RAM read data, valid when `ramrdy` = 1.
- `ramrdy`  in  1  RAM read complete. May arrive 1..N cycles after `ramREN` rises.

## Operation
- States: IDLE, FETCH, RESP.
- IDLE:
  - If any `iREN[i]` = 1, grant the first requester at or after round-robin pointer `rr`, searching in increasing index with wrap.
  - Latch `gnt` and `addr_q = iaddr[gnt]`, then go to FETCH.
  - If there are no requests, stay in IDLE.
- FETCH:
  - `ramREN` = 1 and `ramaddr` = `addr_q`, both held stable.
  - On `ramrdy` = 1, latch `data_q = ramload` and go to RESP. Otherwise stay in FETCH.
- RESP (one cycle):
  - If `iREN[gnt]` = 1 and `iaddr[gnt]` == `addr_q`, drive `iwait[gnt]` = 0.
  - Otherwise the response is stale and is dropped: `iwait` stays all 1.
  - In both cases, `rr` = (`gnt`+1) mod `CPUS`, then go to IDLE.
- `iload[i]` = `data_q` for every i (broadcast); `iwait` is the qualifier.
- `iwait[i]` = 0 only in RESP for i = `gnt`; 1 in every other state and for every other CPU.
- `ramREN` = 1 only in FETCH.
- A requester that drops `iREN` or changes `iaddr` while granted does not abort the RAM read. The read completes and the response is discarded at RESP.
- Only one outstanding RAM read exists at any time.

## Timing
- Reset values: state IDLE, `iwait` all 1, `iload` 0, `ramREN` 0, `ramaddr` 0, `rr` 0, `gnt` 0, `addr_q` 0, `data_q` 0.
- Request seen in IDLE at cycle t:
  - FETCH (`ramREN` = 1) starts at t+1.
  - `ramrdy` first sampled high at cycle t+k (k ≥ 1) gives RESP at t+k+1.
  - IDLE at t+k+2.
- Minimum miss latency, `iREN` rising to `iwait` low: 2 cycles with a 1-cycle RAM.
- Back-to-back service: a new grant can occur in the IDLE cycle immediately after RESP, so each grant takes 3 cycles plus extra RAM wait cycles.
- Simultaneous requests: exactly one grant per IDLE cycle. The loser keeps `iwait` = 1 until it is served.
- Fairness: with all CPUs requesting continuously, each is served within `CPUS` grants.
- `ramrdy` outside FETCH is ignored.
- `RST` asserted in any state, including mid-FETCH: the next cycle is IDLE with reset values. `ramREN` drops, and any later `ramrdy` for the abandoned read is ignored.
- `CPUS` = 1: `rr` is constant 0 and the arbiter degenerates to a pass-through.

## Structure
- `word_t` comes from `cpu_types_pkg`.
- Add to `cpu_types_pkg`:
  - `imemctl_state_t` (enum IDLE, FETCH, RESP).
  - `localparam` for the maximum `CPUS`.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: `req[N]`, `ptr`.
  - Outputs: one-hot `gnt_oh`, index `gnt_idx`, `any`.
  - Purely combinational.
  - `imem_responder` owns `ptr` and its update.
- Total RTL: roughly 150–250 lines.

## Test plan
- Single miss, `CPUS`=2: CPU0 `iREN`=1, `iaddr`=0x0000_0040; RAM returns 0xDEAD_BEEF after 3 cycles. Required: `ramaddr`=0x40 during FETCH, `iwait[0]`=0 for exactly one cycle with `iload[0]`=0xDEAD_BEEF, `iwait[1]` stays 1.
- Contention: both CPUs request (0x100, 0x200) in the same cycle after reset. Required: CPU0 served first, CPU1 second with 0x200. A repeat contention is then won by CPU1 only if `rr`=1; verify `rr` wraps to 0 after CPU1 is served.
- Stale response: CPU0 requests 0x80 and changes `iaddr` to 0x84 while in FETCH. Required: no `iwait[0]` low for the 0x80 data. A new FETCH for 0x84 follows, and 0x84 data is delivered.
- Reset mid-FETCH: assert `RST` with `ramREN`=1, then pulse `ramrdy`. Required: `ramREN`=0 the next cycle, `iwait` all 1, no response delivered.
- Fairness soak: both CPUs request continuously with a random 1–5 cycle RAM latency for 200 grants. Required: grants alternate strictly 0,1,0,1, and every returned word matches the RAM model for the captured address.
